count_run_sequencer: RTL and testbench
======================================

Name: count_run_sequencer

Overview:
- Control stage directly upstream of the 4-bit enable counter. Generates the counter's reset and enable strobes.
- Run sequence: hold the counter in reset for a fixed number of cycles, issue a programmable number of enable cycles (pausable), drain, then pulse done.
- Also drives a cov_window flag marking the post-reset measurement interval, so benches can gate coverage collection on hardware state instead of hand-placed delays.

Parameters:
- RESET_CYCLES, 4, cycles cnt_reset is held high after start; legal range 1..255.
- DRAIN_CYCLES, 2, idle cycles after the last enable before done; legal range 0..255.
- LEN_W, 8, width of run_len and run_count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sequence; sampled only in IDLE.
- run_len  input  LEN_W  number of enable cycles to issue; latched when start is accepted.
- pause  input  1  while high, the enable stream is suspended.
- abort  input  1  terminate the sequence immediately; no done pulse.
- cnt_reset  output  1  drives the downstream counter's reset.
- cnt_enable  output  1  drives the downstream counter's enable.
- cov_window  output  1  high during the measurement interval (RUN, PAUSED, DRAIN).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on normal completion.
- run_count  output  LEN_W  enable cycles issued in the current or last sequence.

Behaviour:
- States: IDLE, HOLD_RESET, RUN, PAUSED, DRAIN, DONE.
- All outputs are Moore-decoded from registered state; there is no combinational path from input to output.
  - cnt_reset = IDLE | HOLD_RESET.
  - cnt_enable = RUN.
  - cov_window = RUN | PAUSED | DRAIN.
  - done = DONE.
  - busy = !IDLE.
- Reset (synchronous, priority over everything): state IDLE, phase counter 0, latched length 0, run_count 0.
  - Resulting outputs: cnt_reset=1, cnt_enable=0, cov_window=0, busy=0, done=0.
  - Reset asserted mid-sequence returns to IDLE at the next edge.
- abort: second priority. From any non-IDLE state, go to IDLE at the next edge with no done pulse. run_count holds its value. abort in IDLE has no effect.
- IDLE: start=1 at an edge → HOLD_RESET; latch run_len; clear run_count; load phase counter. start in any other state is ignored.
- HOLD_RESET: lasts exactly RESET_CYCLES cycles. Then:
  - latched length ≠ 0 → RUN;
  - latched length = 0 and DRAIN_CYCLES > 0 → DRAIN;
  - otherwise → DONE.
- RUN: every RUN cycle is one enable cycle, and run_count increments at that cycle's closing edge. Transition checks at each RUN edge, in priority order:
  - run_count+1 == latched length → DRAIN, or DONE if DRAIN_CYCLES = 0; this takes priority over pause;
  - else pause=1 → PAUSED;
  - else stay in RUN.
- PAUSED: run_count frozen, cnt_enable=0, cov_window=1. pause=0 at an edge → RUN. Pause therefore has one cycle of latency in each direction.
- DRAIN: lasts exactly DRAIN_CYCLES cycles, then → DONE.
- DONE: lasts one cycle (done=1), then → IDLE.
- Invariant: cnt_enable is high for exactly run_len cycles per completed sequence.
- run_count never wraps; run_len max (2^LEN_W−1) yields exactly that many enables.
- run_count holds its final value through IDLE until the next accepted start.
- Reference timing, defaults, start sampled at edge 0, run_len=3:
  - cnt_reset high through cycle 4;
  - RUN in cycles 5–7;
  - DRAIN in cycles 8–9;
  - DONE in cycle 10;
  - IDLE from cycle 11.

Test Plan:
- Basic sequence: defaults, run_len=3, start pulse at edge 0 → cnt_reset high cycles 0–4; cnt_enable high cycles 5–7; cov_window high 5–9; done pulse at cycle 10; run_count=3; downstream counter reads 3.
- Pause: run_len=5, pause high for 3 cycles starting in the 2nd RUN cycle → exactly 5 enable cycles total; 3 PAUSED cycles with cov_window=1; done delayed by 3 cycles versus the unpaused run; run_count=5.
- Zero length: run_len=0 → no cnt_enable; cov_window high only for the 2 DRAIN cycles; done 7 cycles after start; run_count=0.
- Abort: run_len=10, abort in the 4th RUN cycle → IDLE next edge; cnt_reset=1; no done pulse; run_count holds 3 or 4 according to the edge at which abort is sampled; a following start runs a fresh, clean sequence.
- Ignored start, reset mid-run: start re-pulsed during RUN → ignored, sequence length unchanged. Synchronous reset asserted in DRAIN → all outputs at reset values next edge; run_count=0.
- Max length: LEN_W=8, run_len=255 → exactly 255 enable cycles; run_count=255 with no wrap; done pulse follows 2 DRAIN cycles.

Source files
------------

// File: rtl/count_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : count_run_sequencer
//  Description : Control stage feeding a downstream enable counter. On start
//                it holds the counter in reset for RESET_CYCLES cycles, issues
//                a latched number of enable cycles (pausable), drains for
//                DRAIN_CYCLES cycles and then pulses done. Also flags the
//                post-reset measurement interval on cov_window.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                start, run_len   - begin a sequence / enable cycles to issue
//                pause, abort     - suspend enables / terminate sequence
//                cnt_reset        - downstream counter reset
//                cnt_enable       - downstream counter enable
//                cov_window       - high in RUN, PAUSED, DRAIN
//                busy, done       - not idle / one-cycle completion pulse
//                run_count        - enables issued in current/last sequence
//  Revision    : 1.0 - initial release
// ============================================================================
module count_run_sequencer #(
    parameter int RESET_CYCLES = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int LEN_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] run_len,
    input  logic             pause,
    input  logic             abort,
    output logic             cnt_reset,
    output logic             cnt_enable,
    output logic             cov_window,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] run_count
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HOLD_RESET = 3'd1,
        RUN        = 3'd2,
        PAUSED     = 3'd3,
        DRAIN      = 3'd4,
        DONE       = 3'd5
    } state_t;

    // Phase counter counts down to zero; loaded with length-1 so a phase
    // lasts exactly the programmed number of cycles.
    localparam logic [7:0] RESET_LOAD = 8'(RESET_CYCLES - 1);
    localparam logic [7:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 8'(DRAIN_CYCLES - 1) : 8'd0;
    localparam bit         HAS_DRAIN  = (DRAIN_CYCLES > 0);

    state_t             state;
    state_t             state_next;
    logic [7:0]         phase;
    logic [7:0]         phase_next;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_next;
    logic [LEN_W-1:0]   count_next;
    logic [LEN_W:0]     count_inc;

    // One extra bit so the terminal compare can never be fooled by a wrap.
    assign count_inc = {1'b0, run_count} + {{LEN_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 8'd0;
            len       <= '0;
            run_count <= '0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            len       <= len_next;
            run_count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_next = phase;
        len_next   = len;
        count_next = run_count;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = HOLD_RESET;
                    len_next   = run_len;
                    count_next = '0;
                    phase_next = RESET_LOAD;
                end
            end
            HOLD_RESET: begin
                if (phase == 8'd0) begin
                    if (len != '0) begin
                        state_next = RUN;
                    end else if (HAS_DRAIN) begin
                        state_next = DRAIN;
                        phase_next = DRAIN_LOAD;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    phase_next = phase - 8'd1;
                end
            end
            RUN: begin
                // Every RUN cycle is an enable cycle, so it always counts;
                // reaching the length wins over a simultaneous pause.
                count_next = count_inc[LEN_W-1:0];
                if (count_inc == {1'b0, len}) begin
                    if (HAS_DRAIN) begin
                        state_next = DRAIN;
                        phase_next = DRAIN_LOAD;
                    end else begin
                        state_next = DONE;
                    end
                end else if (pause) begin
                    state_next = PAUSED;
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_next = RUN;
                end
            end
            DRAIN: begin
                if (phase == 8'd0) begin
                    state_next = DONE;
                end else begin
                    phase_next = phase - 8'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides everything except reset; the enable at the abort
        // edge is not counted, so run_count holds its current value.
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            phase_next = phase;
            count_next = run_count;
        end
    end

    assign cnt_reset  = (state == IDLE) || (state == HOLD_RESET);
    assign cnt_enable = (state == RUN);
    assign cov_window = (state == RUN) || (state == PAUSED) || (state == DRAIN);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_count_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_run_sequencer
//  Description : Directed self-checking bench for count_run_sequencer with
//                default parameters. Cycle n is the interval following clock
//                edge n-1; start is presented in cycle 0 and sampled at edge 0.
//                Output vector order: {cnt_reset,cnt_enable,cov_window,busy,done}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_run_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] run_len;
    logic       pause;
    logic       abort;
    logic       cnt_reset;
    logic       cnt_enable;
    logic       cov_window;
    logic       busy;
    logic       done;
    logic [7:0] run_count;
    logic [3:0] dcnt;
    logic [4:0] outs;

    int tests  = 0;
    int failed = 0;
    int en_cnt = 0;

    count_run_sequencer #(
        .RESET_CYCLES (4),
        .DRAIN_CYCLES (2),
        .LEN_W        (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .run_len    (run_len),
        .pause      (pause),
        .abort      (abort),
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .cov_window (cov_window),
        .busy       (busy),
        .done       (done),
        .run_count  (run_count)
    );

    always #5 clk = ~clk;

    // Downstream 4-bit enable counter driven by the sequencer.
    always @(posedge clk) begin
        if (cnt_reset)       dcnt <= 4'd0;
        else if (cnt_enable) dcnt <= dcnt + 4'd1;
    end

    assign outs = {cnt_reset, cnt_enable, cov_window, busy, done};

    task automatic tick;
        @(posedge clk);
        #1;
        if (cnt_enable) en_cnt++;
    endtask

    task automatic check_vec(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        run_len = 8'd0;
        pause   = 1'b0;
        abort   = 1'b0;
        tick;
        tick;
        reset = 1'b0;

        // Reset state
        check_vec("reset_outs", outs, 5'b10000);
        check_int("reset_count", int'(run_count), 0);

        // Basic sequence, run_len=3
        run_len = 8'd3;
        start   = 1'b1;
        en_cnt  = 0;
        check_vec("basic_c0", outs, 5'b10000);
        for (int n = 1; n <= 11; n++) begin
            tick;
            start = 1'b0;
            check_vec($sformatf("basic_c%0d", n), outs,
                      {(n <= 4) || (n >= 11), (n >= 5) && (n <= 7), (n >= 5) && (n <= 9),
                       (n >= 1) && (n <= 10), n == 10});
        end
        check_int("basic_count", int'(run_count), 3);
        check_int("basic_enables", en_cnt, 3);
        check_int("basic_downstream", int'(dcnt), 3);

        // Pause: run_len=5, pause high in cycles 6..8
        run_len = 8'd5;
        start   = 1'b1;
        en_cnt  = 0;
        for (int n = 1; n <= 16; n++) begin
            tick;
            start = 1'b0;
            if (n == 6) pause = 1'b1;
            if (n == 9) pause = 1'b0;
            check_vec($sformatf("pause_c%0d", n), outs,
                      {(n <= 4) || (n >= 16),
                       (n == 5) || (n == 6) || (n == 10) || (n == 11) || (n == 12),
                       (n >= 5) && (n <= 14), (n >= 1) && (n <= 15), n == 15});
        end
        check_int("pause_count", int'(run_count), 5);
        check_int("pause_enables", en_cnt, 5);

        // Zero length
        run_len = 8'd0;
        start   = 1'b1;
        en_cnt  = 0;
        for (int n = 1; n <= 8; n++) begin
            tick;
            start = 1'b0;
            check_vec($sformatf("zero_c%0d", n), outs,
                      {(n <= 4) || (n >= 8), 1'b0, (n >= 5) && (n <= 6),
                       (n >= 1) && (n <= 7), n == 7});
        end
        check_int("zero_count", int'(run_count), 0);
        check_int("zero_enables", en_cnt, 0);

        // Abort sampled at the closing edge of the 4th RUN cycle
        run_len = 8'd10;
        start   = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick;
            start = 1'b0;
            if (n == 8) abort = 1'b1;
            if (n == 9) begin
                abort = 1'b0;
                check_int("abort_count_c9", int'(run_count), 3);
            end
            check_vec($sformatf("abort_c%0d", n), outs,
                      {(n <= 4) || (n >= 9), (n >= 5) && (n <= 8), (n >= 5) && (n <= 8),
                       (n >= 1) && (n <= 8), 1'b0});
        end
        check_int("abort_count_hold", int'(run_count), 3);

        // Fresh sequence after abort, run_len=2
        run_len = 8'd2;
        start   = 1'b1;
        en_cnt  = 0;
        for (int n = 1; n <= 10; n++) begin
            tick;
            start = 1'b0;
            check_vec($sformatf("fresh_c%0d", n), outs,
                      {(n <= 4) || (n >= 10), (n >= 5) && (n <= 6), (n >= 5) && (n <= 8),
                       (n >= 1) && (n <= 9), n == 9});
        end
        check_int("fresh_count", int'(run_count), 2);
        check_int("fresh_enables", en_cnt, 2);

        // Start re-pulsed during RUN is ignored; reset asserted in DRAIN
        run_len = 8'd4;
        start   = 1'b1;
        en_cnt  = 0;
        for (int n = 1; n <= 10; n++) begin
            tick;
            start = 1'b0;
            if (n == 6) begin
                start   = 1'b1;
                run_len = 8'd9;
            end
            if (n == 9) begin
                check_int("ign_count_drain", int'(run_count), 4);
                check_int("ign_enables", en_cnt, 4);
                reset = 1'b1;
            end
            check_vec($sformatf("ign_c%0d", n), outs,
                      {(n <= 4) || (n >= 10), (n >= 5) && (n <= 8), (n >= 5) && (n <= 9),
                       (n >= 1) && (n <= 9), 1'b0});
        end
        reset = 1'b0;
        check_int("ign_reset_count", int'(run_count), 0);
        tick;
        check_vec("ign_post_reset", outs, 5'b10000);

        // Max length, run_len=255
        run_len = 8'd255;
        start   = 1'b1;
        en_cnt  = 0;
        for (int n = 1; n <= 263; n++) begin
            tick;
            start = 1'b0;
            check_vec($sformatf("max_c%0d", n), outs,
                      {(n <= 4) || (n >= 263), (n >= 5) && (n <= 259), (n >= 5) && (n <= 261),
                       (n >= 1) && (n <= 262), n == 262});
        end
        check_int("max_count", int'(run_count), 255);
        check_int("max_enables", en_cnt, 255);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
